// File: rtl/fdma_frame_wr_ctrl.sv
// Write-side front end for the FDMA master: buffers a framed stream in an FWFT FIFO,
// commits buffered beats as FDMA write requests and places each frame in a DDR ring.
module fdma_frame_wr_ctrl #(
    parameter int unsigned                 M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                 M_AXI_DATA_WIDTH = 128,
    parameter int unsigned                 FIFO_DEPTH       = 512,
    parameter int unsigned                 BURST_BEATS      = 64,
    parameter logic [M_AXI_ADDR_WIDTH-1:0] BUF_BASE         = 32'h1000_0000,
    parameter logic [31:0]                 BUF_BEATS        = 32'd65536
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_aresetn,
    input  logic [M_AXI_DATA_WIDTH-1:0] s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [M_AXI_ADDR_WIDTH-1:0] fdma_w_addr,
    output logic                        fdma_w_areq,
    output logic [31:0]                 fdma_w_size,
    input  logic                        fdma_w_busy,
    output logic [M_AXI_DATA_WIDTH-1:0] fdma_w_data,
    input  logic                        fdma_w_valid,
    output logic                        fdma_w_ready,
    output logic                        frame_done,
    output logic [31:0]                 frame_beats
);
    localparam int unsigned AXI_BYTES  = M_AXI_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(AXI_BYTES);
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_e;

    logic [M_AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                 count_q, count_d, avail_q, avail_d;
    logic                        run_q, run_d, flush_q, flush_d, tail_q, tail_d, done_q, done_d;
    state_e                      state_q, state_d;
    logic [31:0]                 beat_off_q, beat_off_d, xfer_cnt_q, xfer_cnt_d;
    logic [31:0]                 frame_cnt_q, frame_cnt_d, size_q, size_d, frame_beats_q, frame_beats_d;
    logic [M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                        push, pop, fifo_full;
    logic [31:0]                 avail32, ring_left, len, next_off;

    assign fifo_full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign s_ready      = run_q && !fifo_full && !flush_q;
    assign push         = s_valid && s_ready;
    assign pop          = fdma_w_valid && (count_q != '0);
    assign fdma_w_data  = mem_q[rd_ptr_q];
    assign fdma_w_areq  = (state_q == REQ);
    assign fdma_w_ready = (state_q == XFER);
    assign fdma_w_addr  = addr_q;
    assign fdma_w_size  = size_q;
    assign frame_done   = done_q;
    assign frame_beats  = frame_beats_q;

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        run_d    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

        avail32   = 32'(avail_q);
        ring_left = BUF_BEATS - beat_off_q;
        len       = 32'(BURST_BEATS);
        if (avail32 < len)   len = avail32;
        if (ring_left < len) len = ring_left;
        next_off  = beat_off_q + size_q;

        state_d       = state_q;
        avail_d       = avail_q + (PW+1)'(push);
        flush_d       = flush_q || (push && s_last);
        tail_d        = tail_q;
        beat_off_d    = beat_off_q;
        xfer_cnt_d    = xfer_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        addr_d        = addr_q;
        size_d        = size_q;
        frame_beats_d = frame_beats_q;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (avail32 >= 32'(BURST_BEATS) || (flush_q && avail32 != '0)) begin
                    state_d     = REQ;
                    addr_d      = BUF_BASE + (M_AXI_ADDR_WIDTH'(beat_off_q) << BYTE_SHIFT);
                    size_d      = len;
                    avail_d     = avail_q + (PW+1)'(push) - (PW+1)'(len);
                    xfer_cnt_d  = '0;
                    frame_cnt_d = frame_cnt_q + len;
                    // Input is stalled while flushing, so avail is exactly the frame remainder.
                    if (flush_q && len == avail32) begin
                        tail_d  = 1'b1;
                        flush_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (fdma_w_busy) state_d = XFER;
            end
            XFER: begin
                if (pop) xfer_cnt_d = xfer_cnt_q + 32'd1;
                if (xfer_cnt_q == size_q && !fdma_w_busy) begin
                    beat_off_d = (next_off == BUF_BEATS) ? '0 : next_off;
                    if (tail_q) begin
                        state_d       = DONE;
                        tail_d        = 1'b0;
                        done_d        = 1'b1;
                        frame_beats_d = frame_cnt_q;
                        frame_cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                beat_off_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            run_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            avail_q       <= '0;
            flush_q       <= 1'b0;
            tail_q        <= 1'b0;
            done_q        <= 1'b0;
            state_q       <= IDLE;
            beat_off_q    <= '0;
            xfer_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            addr_q        <= BUF_BASE;
            size_q        <= '0;
            frame_beats_q <= '0;
        end else begin
            run_q         <= run_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            avail_q       <= avail_d;
            flush_q       <= flush_d;
            tail_q        <= tail_d;
            done_q        <= done_d;
            state_q       <= state_d;
            beat_off_q    <= beat_off_d;
            xfer_cnt_q    <= xfer_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            frame_beats_q <= frame_beats_d;
        end
    end

    // NOTE: FIFO storage is not reset; pointers and count define which entries are valid.
    always_ff @(posedge m_axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end
endmodule
